// File: rtl/des_key_if.sv
// Key-in / subkey-out handshake bundle for des_key_schedule.
// parity_err exists only when DES_KEY_PARITY_CHECK_EN is defined.
interface des_key_if;
    localparam int unsigned KEY_W = 64;
    localparam int unsigned SK_W  = 48;
    localparam int unsigned IDX_W = 4;

    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key;
    logic             decrypt;
    logic             abort;
    logic             subkey_valid;
    logic             subkey_ready;
    logic [SK_W-1:0]  subkey;
    logic [IDX_W-1:0] round_idx;
    logic             last;
    logic             busy;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic             parity_err;
`endif

    modport master (
        output key_valid, key, decrypt, abort, subkey_ready,
        input  key_ready, subkey_valid, subkey, round_idx, last, busy
`ifdef DES_KEY_PARITY_CHECK_EN
        , input parity_err
`endif
    );

    modport slave (
        input  key_valid, key, decrypt, abort, subkey_ready,
        output key_ready, subkey_valid, subkey, round_idx, last, busy
`ifdef DES_KEY_PARITY_CHECK_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 load, one PC-2 subkey per accepted beat, K1..Kn or Kn..K1.
// Optional DES_KEY_PARITY_CHECK_EN rejects keys with any even-parity byte and pulses parity_err.
module des_key_schedule #(
    parameter int unsigned ROUNDS     = 16,
    parameter logic [15:0] SHIFT_MASK = 16'h8103
) (
    input  logic     clk,
    input  logic     rst,
    des_key_if.slave kif
);
    localparam int unsigned HALF_W = 28;
    localparam int unsigned CD_W   = 56;
    localparam int unsigned KEY_W  = 64;
    localparam int unsigned SK_W   = 48;
    localparam int unsigned IDX_W  = 4;

    // FIPS 46-3 tables, 1-based bit numbers with bit 1 as MSB
    localparam int PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_TAB [SK_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic int unsigned total_shift();
        int unsigned s;
        s = 0;
        for (int unsigned i = 0; i < ROUNDS; i++) s += (SHIFT_MASK[i] ? 1 : 2);
        return s % HALF_W;
    endfunction

    localparam int unsigned ENC_LOAD_ROT = SHIFT_MASK[0] ? 1 : 2;
    localparam int unsigned DEC_LOAD_ROT = total_shift();

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input int unsigned n);
        return (x << n) | (x >> (HALF_W - n));
    endfunction

    // One schedule step: left by 1/2 for encrypt, right by 1/2 for decrypt
    function automatic logic [HALF_W-1:0] step(input logic [HALF_W-1:0] x, input logic right,
                                               input logic one);
        int unsigned amt;
        if (right) amt = one ? HALF_W - 1 : HALF_W - 2;
        else       amt = one ? 1 : 2;
        return rotl(x, amt);
    endfunction

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(CD_W); i++) r[int'(CD_W) - 1 - i] = k[int'(KEY_W) - PC1_TAB[i]];
        return r;
    endfunction

    function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SK_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(SK_W); i++) r[int'(SK_W) - 1 - i] = cd[int'(CD_W) - PC2_TAB[i]];
        return r;
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [HALF_W-1:0] c_q, d_q;
    logic [IDX_W-1:0]  beat;
    logic [IDX_W-1:0]  round_idx_q;
    logic              mode;
    logic              last_q;

    logic [CD_W-1:0]   cd_load;
    logic [HALF_W-1:0] c_load, d_load;
    logic [IDX_W-1:0]  enc_sel;
    logic              step_one;
    logic              final_beat;
    logic              key_ok;
    logic              accept;

`ifdef DES_KEY_PARITY_CHECK_EN
    logic parity_err_q;

    function automatic logic odd_bytes(input logic [KEY_W-1:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) ok &= ^k[8*b +: 8];
        return ok;
    endfunction

    assign key_ok         = odd_bytes(kif.key);
    assign kif.parity_err = parity_err_q;
`else
    assign key_ok = 1'b1;
`endif

    assign cd_load = pc1(kif.key);
    assign c_load  = kif.decrypt ? rotl(cd_load[CD_W-1:HALF_W], DEC_LOAD_ROT)
                                 : rotl(cd_load[CD_W-1:HALF_W], ENC_LOAD_ROT);
    assign d_load  = kif.decrypt ? rotl(cd_load[HALF_W-1:0], DEC_LOAD_ROT)
                                 : rotl(cd_load[HALF_W-1:0], ENC_LOAD_ROT);

    // Encrypt steps with the next round's shift, decrypt undoes the outgoing round's shift
    assign enc_sel    = beat + IDX_W'(1);
    assign step_one   = mode ? SHIFT_MASK[round_idx_q] : SHIFT_MASK[enc_sel];
    assign final_beat = (beat == IDX_W'(ROUNDS - 1));
    assign accept     = (state == IDLE) && kif.key_valid && !kif.abort && key_ok;

    assign kif.key_ready    = (state == IDLE) && !kif.abort;
    assign kif.subkey_valid = (state == RUN);
    assign kif.busy         = (state == RUN);
    assign kif.subkey       = pc2({c_q, d_q});
    assign kif.round_idx    = round_idx_q;
    assign kif.last         = last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            c_q          <= '0;
            d_q          <= '0;
            beat         <= '0;
            round_idx_q  <= '0;
            mode         <= 1'b0;
            last_q       <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
`ifdef DES_KEY_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= RUN;
                        mode        <= kif.decrypt;
                        c_q         <= c_load;
                        d_q         <= d_load;
                        beat        <= '0;
                        round_idx_q <= kif.decrypt ? IDX_W'(ROUNDS - 1) : '0;
                        last_q      <= (ROUNDS == 1);
                    end
`ifdef DES_KEY_PARITY_CHECK_EN
                    else if (kif.key_valid && !kif.abort) begin
                        parity_err_q <= 1'b1;
                    end
`endif
                end
                RUN: begin
                    if (kif.abort || (kif.subkey_ready && final_beat)) begin
                        state       <= IDLE;
                        beat        <= '0;
                        round_idx_q <= '0;
                        last_q      <= 1'b0;
                    end else if (kif.subkey_ready) begin
                        beat        <= beat + IDX_W'(1);
                        round_idx_q <= mode ? round_idx_q - IDX_W'(1) : round_idx_q + IDX_W'(1);
                        last_q      <= ((beat + IDX_W'(1)) == IDX_W'(ROUNDS - 1));
                        c_q         <= step(c_q, mode, step_one);
                        d_q         <= step(d_q, mode, step_one);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: vector table of full schedules plus abort, reset and parity sequences.
module tb_des_key_schedule;
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int DES_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
    localparam logic [47:0] K2_A   = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic        rnd;
        logic        noise;
        logic [47:0] k_first;
        logic [47:0] k_second;
        logic [47:0] k_last;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    vec_t vecs [5];

    des_key_if kif ();

    des_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    // Reference: K_n from PC-1, the cumulative shift up to round n, then PC-2
    function automatic logic [47:0] model_subkey(input logic [63:0] k, input int n);
        logic [1:64] kb;
        logic [1:28] c0, d0, c, d;
        logic [1:56] cd;
        logic [1:48] ks;
        int s;
        kb = k;
        s  = 0;
        for (int r = 0; r < n; r++) s += DES_SHIFTS[r];
        s = s % 28;
        for (int j = 1; j <= 28; j++) begin
            c0[j] = kb[PC1[j-1]];
            d0[j] = kb[PC1[j+27]];
        end
        for (int j = 1; j <= 28; j++) begin
            c[j] = c0[((j - 1 + s) % 28) + 1];
            d[j] = d0[((j - 1 + s) % 28) + 1];
        end
        cd = {c, d};
        for (int j = 1; j <= 48; j++) ks[j] = cd[PC2[j-1]];
        return ks;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        kif.subkey_ready = 1'b1;
        while (kif.subkey_valid && n < 40) begin
            tick();
            n++;
        end
        kif.subkey_ready = 1'b0;
        chk("drain_done", 64'(kif.subkey_valid), 64'(0));
    endtask

    task automatic run_vec(input vec_t v);
        int beat, idx, cycles;
        logic rdy;
        chk("ready_before", 64'(kif.key_ready), 64'(1));
        kif.key       = v.key;
        kif.decrypt   = v.dec;
        kif.key_valid = 1'b1;
        tick();
        // key_valid held with a different key while running must be ignored
        if (v.noise) begin
            kif.key     = ~v.key;
            kif.decrypt = ~v.dec;
        end else begin
            kif.key_valid = 1'b0;
        end
        beat   = 0;
        cycles = 0;
        while (beat < 16 && cycles < 200) begin
            idx = v.dec ? 15 - beat : beat;
            chk("subkey_valid", 64'(kif.subkey_valid), 64'(1));
            chk("subkey", 64'(kif.subkey), 64'(model_subkey(v.key, idx + 1)));
            chk("round_idx", 64'(kif.round_idx), 64'(idx));
            chk("last", 64'(kif.last), 64'(beat == 15));
            chk("busy", 64'(kif.busy), 64'(1));
            if (beat == 0)  chk("first_subkey", 64'(kif.subkey), 64'(v.k_first));
            if (beat == 1)  chk("second_subkey", 64'(kif.subkey), 64'(v.k_second));
            if (beat == 15) chk("final_subkey", 64'(kif.subkey), 64'(v.k_last));
            rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            kif.subkey_ready = rdy;
            tick();
            if (v.noise && beat == 15 && rdy) kif.key_valid = 1'b0;
            cycles++;
            if (rdy) beat++;
        end
        kif.key_valid    = 1'b0;
        kif.subkey_ready = 1'b0;
        chk("beats_done", 64'(beat), 64'(16));
        chk("ready_after", 64'(kif.key_ready), 64'(1));
        chk("valid_after", 64'(kif.subkey_valid), 64'(0));
        chk("busy_after", 64'(kif.busy), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst              = 1'b1;
        kif.key_valid    = 1'b0;
        kif.key          = '0;
        kif.decrypt      = 1'b0;
        kif.abort        = 1'b0;
        kif.subkey_ready = 1'b0;

        vecs[0] = '{KEY_A, 1'b0, 1'b0, 1'b0, K1_A, K2_A, K16_A};
        vecs[1] = '{KEY_A, 1'b1, 1'b0, 1'b0, K16_A, model_subkey(KEY_A, 15), K1_A};
        vecs[2] = '{KEY_A, 1'b0, 1'b1, 1'b1, K1_A, K2_A, K16_A};
        vecs[3] = '{64'h0123456789ABCDEF, 1'b1, 1'b1, 1'b0,
                    model_subkey(64'h0123456789ABCDEF, 16), model_subkey(64'h0123456789ABCDEF, 15),
                    model_subkey(64'h0123456789ABCDEF, 1)};
        vecs[4] = '{64'hFEDCBA9876543210, 1'b0, 1'b0, 1'b0,
                    model_subkey(64'hFEDCBA9876543210, 1), model_subkey(64'hFEDCBA9876543210, 2),
                    model_subkey(64'hFEDCBA9876543210, 16)};

        #12;
        chk("rst_key_ready", 64'(kif.key_ready), 64'(1));
        chk("rst_subkey_valid", 64'(kif.subkey_valid), 64'(0));
        chk("rst_busy", 64'(kif.busy), 64'(0));
        chk("rst_last", 64'(kif.last), 64'(0));
        chk("rst_round_idx", 64'(kif.round_idx), 64'(0));
        chk("rst_subkey", 64'(kif.subkey), 64'(0));
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("rst_parity_err", 64'(kif.parity_err), 64'(0));
`endif
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Abort at beat 5 with a simultaneous handshake, then a clean restart
        kif.key = KEY_A; kif.decrypt = 1'b0; kif.key_valid = 1'b1;
        tick();
        kif.key_valid = 1'b0;
        kif.subkey_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_pre_idx", 64'(kif.round_idx), 64'(5));
        chk("abort_pre_subkey", 64'(kif.subkey), 64'(model_subkey(KEY_A, 6)));
        kif.abort = 1'b1;
        tick();
        chk("abort_valid", 64'(kif.subkey_valid), 64'(0));
        chk("abort_busy", 64'(kif.busy), 64'(0));
        chk("abort_key_ready", 64'(kif.key_ready), 64'(0));
        kif.subkey_ready = 1'b0;
        kif.key_valid = 1'b1;
        tick();
        chk("abort_blocks_key", 64'(kif.busy), 64'(0));
        kif.abort = 1'b0;
        #1;
        chk("abort_release_ready", 64'(kif.key_ready), 64'(1));
        tick();
        kif.key_valid = 1'b0;
        chk("restart_busy", 64'(kif.busy), 64'(1));
        chk("restart_k1", 64'(kif.subkey), 64'(K1_A));
        chk("restart_idx", 64'(kif.round_idx), 64'(0));
        drain();

        // Hold without ready, then asynchronous reset mid-cycle
        kif.key = KEY_A; kif.decrypt = 1'b0; kif.key_valid = 1'b1;
        tick();
        kif.key_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_subkey", 64'(kif.subkey), 64'(K1_A));
            chk("hold_idx", 64'(kif.round_idx), 64'(0));
            chk("hold_valid", 64'(kif.subkey_valid), 64'(1));
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(kif.subkey_valid), 64'(0));
        chk("arst_key_ready", 64'(kif.key_ready), 64'(1));
        chk("arst_busy", 64'(kif.busy), 64'(0));
        chk("arst_subkey", 64'(kif.subkey), 64'(0));
        #2;
        rst = 1'b0;

`ifdef DES_KEY_PARITY_CHECK_EN
        tick();
        kif.key = 64'h123457799BBCDFF1; kif.decrypt = 1'b0; kif.key_valid = 1'b1;
        tick();
        kif.key_valid = 1'b0;
        chk("parity_err_pulse", 64'(kif.parity_err), 64'(1));
        chk("parity_busy", 64'(kif.busy), 64'(0));
        tick();
        chk("parity_err_clear", 64'(kif.parity_err), 64'(0));
        chk("parity_still_idle", 64'(kif.busy), 64'(0));
        kif.key = KEY_A; kif.key_valid = 1'b1;
        tick();
        kif.key_valid = 1'b0;
        chk("parity_retry_busy", 64'(kif.busy), 64'(1));
        chk("parity_retry_k1", 64'(kif.subkey), 64'(K1_A));
        chk("parity_retry_err", 64'(kif.parity_err), 64'(0));
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES subkey generator. Accepts a 64-bit key (FIPS 46-3 numbering, bit 1 = key[63]) and applies PC-1 into 28-bit C/D registers.
- Streams one 48-bit PC-2 subkey per accepted beat: K1..Kn in encrypt mode, Kn..K1 in decrypt mode.
- Sits between the key register file and the round datapath, replacing the stand-alone PC-1 stage with a full, back-pressurable key schedule.

Parameters:
- ROUNDS, 16, number of subkeys per key; legal range 1..16.
- SHIFT_MASK, 16'h8103, bit i-1 = 1 means round i rotates by 1, otherwise by 2. The default is the DES schedule.

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- key_valid  in  1  key offered
- key_ready  out  1  block can accept a key
- key  in  64  DES key; parity bits key[56],key[48],...,key[0] are ignored by PC-1
- decrypt  in  1  sampled with the key; 1 = reverse subkey order
- abort  in  1  discard the current schedule, return to IDLE
- subkey_valid  out  1  subkey presented
- subkey_ready  in  1  consumer accepts subkey
- subkey  out  48  PC-2(C,D); DES bit 1 = subkey[47]
- round_idx  out  4  DES round number minus 1 of the presented subkey (0 = K1)
- last  out  1  presented subkey is the final one of the schedule
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; C=D=0; beat count=0; mode=0; key_ready=1; subkey_valid=0; last=0; busy=0; round_idx=0; parity_err=0. subkey reads PC-2(0,0)=0.
- States: IDLE, RUN.
- IDLE:
  - key_ready = !abort.
  - key_valid && key_ready latches mode=decrypt and PC-1(key) into C/D, then goes to RUN.
  - Encrypt load: C/D = PC-1 result rotated left by shift(1).
  - Decrypt load: C/D = PC-1 result rotated left by S mod 28, where S = sum of shift(1..ROUNDS), an elaboration-time constant. For ROUNDS=16, S=28, so load is plain PC-1.
- Latency: key accepted at edge N gives subkey_valid=1 after edge N; first subkey is visible in cycle N+1.
- RUN:
  - key_ready=0; subkey_valid=1; subkey is combinational PC-2 of the C/D registers.
  - Encrypt: round_idx = beat. Decrypt: round_idx = ROUNDS-1-beat.
  - last = (beat == ROUNDS-1).
  - Beat advances only on subkey_valid && subkey_ready. Without ready, subkey, round_idx and last hold stable indefinitely.
  - On a non-final advance, encrypt rotates C/D left by shift(round_idx+2). Decrypt rotates right by shift(round_idx+1), using the outgoing round's shift.
  - On the final advance, state goes to IDLE and beat=0; key_ready=1 from the next cycle. No back-to-back key acceptance occurs in the same cycle as the last handshake.
- Rotations: 28-bit circular, applied independently to C and D; the bit leaving the MSB wraps to the LSB (left rotation).
- abort:
  - Highest priority. In RUN it forces IDLE at the next edge, and a simultaneous subkey handshake does not count.
  - In IDLE it blocks key acceptance.
  - C/D are not cleared by abort.
- ROUNDS=1: a single beat with last=1. Encrypt and decrypt produce the same K1.
- key_valid while in RUN is ignored; the key is not captured.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- With the macro:
  - Extra output parity_err (1 bit).
  - A key is accepted only if every byte has odd parity.
  - A handshaked key with any even-parity byte stays in IDLE, C/D are unchanged, and parity_err pulses high for exactly one cycle after that edge.
  - key_ready still behaves as above.
- Without the macro: no parity_err port; parity bits are ignored and every handshaked key is accepted.

Test Plan:
- Encrypt, key=64'h133457799BBCDFF1, subkey_ready=1 -> beat0 subkey=48'h1B02EFFC7072, round_idx=0; beat1 48'h79AED9DBC9E5; beat15 48'hCB3D8B0E17F5 with last=1; key_ready=1 the cycle after.
- Decrypt with the same key -> first subkey 48'hCB3D8B0E17F5, round_idx=15; final subkey 48'h1B02EFFC7072, round_idx=0, last=1.
- Same encrypt run with subkey_ready toggled pseudo-randomly -> identical 16-subkey sequence; outputs stable while ready=0.
- abort asserted at beat 5 together with subkey_ready=1 -> IDLE next cycle, subkey_valid=0. A new key then restarts cleanly at K1=48'h1B02EFFC7072.
- Reset pulsed mid-RUN, asynchronous to Clk -> subkey_valid=0, key_ready=1, busy=0 immediately, with no wait for an edge.
- With DES_KEY_PARITY_CHECK_EN, key=64'h123457799BBCDFF1 -> parity_err=1 for one cycle, busy stays 0. Retrying with 64'h133457799BBCDFF1 is accepted.
